// File: rtl/dlbf_pkg.sv
// Shared types and sizes for the dlbf slave-side framing stage.
package dlbf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FRAME_LEN_DEF = 1536;
    localparam int FRAME_W       = 12;
    localparam int BEAT_W        = 16;

endpackage

// File: rtl/dlbf_axis_skid.sv
// Two-entry register slice: the head entry drives the output directly, the
// second entry catches the beat accepted while the output is stalled.
module dlbf_axis_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_fire,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ,
    output logic [1:0]   occ_next
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic [1:0]   occ_q, occ_d;
    logic         valid_q, valid_d;
    logic         out_fire;

    assign out_fire = valid_q && out_ready;

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (in_fire) begin
                    head_d = in_data;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (in_fire && out_fire) begin
                    head_d = in_data;
                end else if (in_fire) begin
                    skid_d = in_data;
                    occ_d  = 2'd2;
                end else if (out_fire) begin
                    occ_d = 2'd0;
                end
            end
            default: begin
                // Full: the skid entry moves up; a concurrent input refills it.
                if (out_fire) begin
                    head_d = skid_q;
                    if (in_fire) begin
                        skid_d = in_data;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
        endcase
        valid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            skid_q  <= '0;
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = head_q;
    assign occ       = occ_q;
    assign occ_next  = occ_d;

endmodule

// File: rtl/dlbf_slave_framer.sv
// Armed AXI4-Stream framer: passes niter frames of FRAME_LEN beats (or runs
// forever when niter is 0), regenerates TLAST and flags incoming TLAST errors.
module dlbf_slave_framer
    import dlbf_pkg::*;
#(
    parameter int TDATA_WIDTH = 64,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int FRAME_LEN   = FRAME_LEN_DEF
) (
    input  logic                   s_axis_clk,
    input  logic                   slave_rst,
    input  logic                   start,
    input  logic [FRAME_W-1:0]     niter,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   busy,
    output logic                   done,
    output logic [FRAME_W-1:0]     frame_count,
    output logic [BEAT_W-1:0]      beat_count,
    output logic                   tlast_err,
    output state_e                 dbg_state
);

    // Handshake: a beat moves on either port only in a cycle where valid and
    // ready are both 1; a raised valid holds itself and its payload until then.

    localparam int PW = TDATA_WIDTH + TKEEP_WIDTH + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   niter_q, niter_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [FRAME_W-1:0]   in_frame_q, in_frame_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 err_q, err_d;
    logic                 s_ready_q, s_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 in_fire;
    logic                 out_fire;
    logic                 beat_last;
    logic                 stop_d;
    logic [1:0]           occ, occ_next;
    logic [PW-1:0]        skid_out;

    assign in_fire   = s_axis_tvalid && s_ready_q;
    assign out_fire  = m_axis_tvalid && m_axis_tready;
    assign beat_last = (beat_q == LAST_BEAT);

    dlbf_axis_skid #(.W(PW)) u_skid (
        .clk       (s_axis_clk),
        .rst       (slave_rst),
        .in_fire   (in_fire),
        .in_data   ({s_axis_tdata, s_axis_tkeep, beat_last}),
        .out_ready (m_axis_tready),
        .out_valid (m_axis_tvalid),
        .out_data  (skid_out),
        .occ       (occ),
        .occ_next  (occ_next)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = skid_out;

    always_comb begin
        state_d    = state_q;
        niter_d    = niter_q;
        beat_d     = beat_q;
        in_frame_d = in_frame_q;
        frame_d    = frame_q;
        err_d      = err_q;
        case (state_q)
            ST_RUN: begin
                if (in_fire) begin
                    beat_d = beat_last ? '0 : beat_q + BEAT_W'(1);
                    if (beat_last) begin
                        in_frame_d = in_frame_q + FRAME_W'(1);
                    end
                    if (s_axis_tlast != beat_last) begin
                        err_d = 1'b1;
                    end
                end
                if (out_fire && m_axis_tlast) begin
                    frame_d = frame_q + FRAME_W'(1);
                end
                if ((niter_q != '0) && (frame_q == niter_q) && (occ == 2'd0)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                if (start) begin
                    state_d    = ST_RUN;
                    niter_d    = niter;
                    beat_d     = '0;
                    in_frame_d = '0;
                    frame_d    = '0;
                    err_d      = 1'b0;
                end
            end
        endcase
        // Ready looks at next-cycle occupancy so a full slice never sees a new beat.
        stop_d    = (niter_d != '0) && (in_frame_d == niter_d);
        s_ready_d = (state_d == ST_RUN) && (occ_next != 2'd2) && !stop_d;
        busy_d    = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge s_axis_clk or posedge slave_rst) begin
        if (slave_rst) begin
            state_q    <= ST_IDLE;
            niter_q    <= '0;
            beat_q     <= '0;
            in_frame_q <= '0;
            frame_q    <= '0;
            err_q      <= 1'b0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            niter_q    <= niter_d;
            beat_q     <= beat_d;
            in_frame_q <= in_frame_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign s_axis_tready = s_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign frame_count   = frame_q;
    assign beat_count    = beat_q;
    assign tlast_err     = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dlbf_slave_framer.sv
// Directed bench for dlbf_slave_framer with FRAME_LEN=4 and 64-bit data.
module tb_dlbf_slave_framer;
    import dlbf_pkg::*;

    logic        clk = 1'b0;
    logic        slave_rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] niter = '0;
    logic        s_valid = 1'b0;
    logic        s_tready;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tlast = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        busy, done, tlast_err;
    logic [11:0] frame_count;
    logic [15:0] beat_count;
    state_e      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int occ      = 0;
    bit rdy_pat[4] = '{1, 1, 1, 1};

    logic [63:0] src_d[$];
    logic        src_l[$];
    logic [63:0] out_d[$];
    logic [7:0]  out_k[$];
    logic        out_l[$];

    dlbf_slave_framer #(.TDATA_WIDTH(64), .FRAME_LEN(4)) dut (
        .s_axis_clk    (clk),
        .slave_rst     (slave_rst),
        .start         (start),
        .niter         (niter),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .busy          (busy),
        .done          (done),
        .frame_count   (frame_count),
        .beat_count    (beat_count),
        .tlast_err     (tlast_err),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic drive();
        s_valid = (src_d.size() != 0);
        s_tdata = s_valid ? src_d[0] : 64'h0;
        s_tkeep = s_valid ? src_d[0][7:0] : 8'h0;
        s_tlast = s_valid ? src_l[0] : 1'b0;
        m_ready = rdy_pat[cyc % 4];
    endtask

    task automatic step();
        logic in_f, out_f, ol;
        logic [63:0] od;
        logic [7:0]  ok;
        in_f  = s_valid && s_tready;
        out_f = m_valid && m_ready;
        od = m_tdata; ok = m_tkeep; ol = m_tlast;
        @(posedge clk); #1;
        if (in_f) begin src_d.delete(0); src_l.delete(0); occ++; end
        if (out_f) begin out_d.push_back(od); out_k.push_back(ok); out_l.push_back(ol); occ--; end
        cyc++;
        drive();
    endtask

    // mode 0: correct TLAST, 1: TLAST on beat 1 only, 2: no TLAST at all
    task automatic load_beats(input logic [63:0] base, input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            src_d.push_back(base + 64'(i));
            case (mode)
                0: src_l.push_back((i % 4) == 3);
                1: src_l.push_back(i == 1);
                default: src_l.push_back(1'b0);
            endcase
        end
        drive();
    endtask

    task automatic do_start(input logic [11:0] n);
        start = 1'b1; niter = n;
        step();
        start = 1'b0;
    endtask

    task automatic clear_bench();
        src_d.delete(); src_l.delete(); out_d.delete(); out_k.delete(); out_l.delete();
        occ = 0; cyc = 0;
    endtask

    task automatic apply_reset();
        slave_rst = 1'b1;
        start = 1'b0; niter = '0;
        clear_bench();
        drive();
        repeat (2) @(posedge clk);
        #1 slave_rst = 1'b0;
    endtask

    task automatic run_to_done(input int budget, input string name);
        int k;
        k = 0;
        while (!done && k < budget) begin step(); k++; end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL %s_timeout: done=%0b after %0d cycles, want 1", name, done, k); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_s_tready: got %0b want 0", s_tready); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %0b want 0", m_valid); end
        n_checks++; if (m_tlast !== 1'b0 || m_tdata !== 64'h0 || m_tkeep !== 8'h0) begin n_fail++; $display("FAIL rst_payload: got %0h/%0h/%0b want 0/0/0", m_tdata, m_tkeep, m_tlast); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || tlast_err !== 1'b0) begin n_fail++; $display("FAIL rst_status: got busy=%0b done=%0b err=%0b want 0", busy, done, tlast_err); end
        n_checks++; if (frame_count !== 12'd0 || beat_count !== 16'd0) begin n_fail++; $display("FAIL rst_counts: got %0d/%0d want 0/0", frame_count, beat_count); end
        // IDLE must refuse beats even with valid asserted
        load_beats(64'h0, 3, 0);
        repeat (3) step();
        n_checks++; if (s_tready !== 1'b0 || m_valid !== 1'b0 || beat_count !== 16'd0) begin n_fail++; $display("FAIL idle_refuse: got rdy=%0b mv=%0b beats=%0d want 0/0/0", s_tready, m_valid, beat_count); end
    endtask

    task automatic test_frame_tlast();
        apply_reset();
        load_beats(64'h0, 8, 0);
        do_start(12'd2);
        n_checks++; if (busy !== 1'b1 || s_tready !== 1'b1) begin n_fail++; $display("FAIL start_run: got busy=%0b rdy=%0b want 1/1", busy, s_tready); end
        step();
        n_checks++; if (m_valid !== 1'b1 || m_tdata !== 64'h0 || beat_count !== 16'd1) begin n_fail++; $display("FAIL first_latency: got mv=%0b data=%0h beats=%0d want 1/0/1", m_valid, m_tdata, beat_count); end
        for (int k = 2; k <= 9; k++) begin
            step();
            if (k == 8) begin
                n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL stop_ready: got %0b want 0", s_tready); end
            end
        end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_early: got %0b want 0", done); end
        step();
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL done_time: got done=%0b busy=%0b want 1/0", done, busy); end
        n_checks++; if (out_d.size() != 8) begin n_fail++; $display("FAIL ft_count: got %0d want 8", out_d.size()); end
        for (int i = 0; i < out_d.size(); i++) begin
            n_checks++;
            if (out_d[i] !== 64'(i) || out_k[i] !== 8'(i) || out_l[i] !== ((i % 4) == 3)) begin
                n_fail++; $display("FAIL ft_beat%0d: got %0h/%0h/%0b want %0h/%0h/%0b", i, out_d[i], out_k[i], out_l[i], i, i, (i % 4) == 3);
            end
        end
        n_checks++; if (frame_count !== 12'd2 || tlast_err !== 1'b0) begin n_fail++; $display("FAIL ft_status: got frames=%0d err=%0b want 2/0", frame_count, tlast_err); end
    endtask

    task automatic test_tlast_err();
        apply_reset();
        load_beats(64'h40, 8, 1);
        do_start(12'd2);
        step();
        n_checks++; if (tlast_err !== 1'b0) begin n_fail++; $display("FAIL err_beat0: got %0b want 0", tlast_err); end
        step();
        n_checks++; if (tlast_err !== 1'b1) begin n_fail++; $display("FAIL err_beat1: got %0b want 1", tlast_err); end
        run_to_done(40, "err");
        n_checks++; if (out_d.size() != 8) begin n_fail++; $display("FAIL err_count: got %0d want 8", out_d.size()); end
        for (int i = 0; i < out_l.size(); i++) begin
            n_checks++;
            if (out_l[i] !== ((i % 4) == 3)) begin n_fail++; $display("FAIL err_tlast%0d: got %0b want %0b", i, out_l[i], (i % 4) == 3); end
        end
        n_checks++; if (tlast_err !== 1'b1 || frame_count !== 12'd2) begin n_fail++; $display("FAIL err_sticky: got err=%0b frames=%0d want 1/2", tlast_err, frame_count); end
    endtask

    task automatic test_backpressure();
        int prev_occ, k;
        bit stall;
        logic [63:0] pd;
        apply_reset();
        rdy_pat = '{1, 0, 0, 1};
        load_beats(64'h0, 8, 0);
        do_start(12'd2);
        prev_occ = 0; k = 0;
        while (!done && k < 80) begin
            stall = m_valid && !m_ready;
            pd = m_tdata;
            step(); k++;
            if (stall) begin
                n_checks++;
                if (m_valid !== 1'b1 || m_tdata !== pd) begin n_fail++; $display("FAIL bp_hold: got mv=%0b data=%0h want 1/%0h", m_valid, m_tdata, pd); end
            end
            if (occ == 2 && prev_occ == 2) begin
                n_checks++;
                if (s_tready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %0b want 0 with slice full", s_tready); end
            end
            if (occ > 2) begin
                n_checks++; n_fail++; $display("FAIL bp_overflow: occupancy %0d want <= 2", occ);
            end
            prev_occ = occ;
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: done=%0b want 1", done); end
        n_checks++; if (out_d.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", out_d.size()); end
        for (int i = 0; i < out_d.size(); i++) begin
            n_checks++;
            if (out_d[i] !== 64'(i) || out_l[i] !== ((i % 4) == 3)) begin n_fail++; $display("FAIL bp_beat%0d: got %0h/%0b want %0h/%0b", i, out_d[i], out_l[i], i, (i % 4) == 3); end
        end
        rdy_pat = '{1, 1, 1, 1};
    endtask

    task automatic test_restart();
        apply_reset();
        load_beats(64'h80, 4, 2);
        do_start(12'd1);
        run_to_done(30, "rs_first");
        n_checks++; if (tlast_err !== 1'b1 || frame_count !== 12'd1) begin n_fail++; $display("FAIL rs_first: got err=%0b frames=%0d want 1/1", tlast_err, frame_count); end
        out_d.delete(); out_k.delete(); out_l.delete();
        load_beats(64'h90, 4, 0);
        do_start(12'd1);
        n_checks++; if (tlast_err !== 1'b0 || frame_count !== 12'd0 || beat_count !== 16'd0) begin n_fail++; $display("FAIL rs_clear: got err=%0b frames=%0d beats=%0d want 0/0/0", tlast_err, frame_count, beat_count); end
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL rs_run: got busy=%0b done=%0b want 1/0", busy, done); end
        repeat (5) step();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rs_early: got done=%0b want 0", done); end
        // start on the RUN->DONE edge must be ignored
        start = 1'b1; niter = 12'd1;
        step();
        start = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rs_done: got %0b want 1", done); end
        step();
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rs_ign_start: got done=%0b busy=%0b want 1/0", done, busy); end
        n_checks++; if (out_d.size() != 4) begin n_fail++; $display("FAIL rs_count: got %0d want 4", out_d.size()); end
        for (int i = 0; i < out_d.size(); i++) begin
            n_checks++;
            if (out_d[i] !== 64'h90 + 64'(i) || out_l[i] !== (i == 3)) begin n_fail++; $display("FAIL rs_beat%0d: got %0h/%0b want %0h/%0b", i, out_d[i], out_l[i], 64'h90 + 64'(i), i == 3); end
        end
        n_checks++; if (tlast_err !== 1'b0 || frame_count !== 12'd1) begin n_fail++; $display("FAIL rs_status: got err=%0b frames=%0d want 0/1", tlast_err, frame_count); end
    endtask

    task automatic test_unlimited();
        int k, bad;
        apply_reset();
        load_beats(64'h0, 16400, 0);
        do_start(12'd0);
        k = 0;
        while (!(src_d.size() == 0 && !m_valid) && k < 17000) begin
            // a start while running must not re-arm with a finite niter
            if (k == 100) begin start = 1'b1; niter = 12'd5; end
            if (k == 101) start = 1'b0;
            step(); k++;
        end
        n_checks++; if (out_d.size() != 16400) begin n_fail++; $display("FAIL ul_count: got %0d want 16400", out_d.size()); end
        bad = 0;
        for (int i = 0; i < out_d.size(); i++)
            if (out_d[i] !== 64'(i) || out_l[i] !== ((i % 4) == 3)) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ul_data: got %0d bad beats want 0", bad); end
        n_checks++; if (frame_count !== 12'd4) begin n_fail++; $display("FAIL ul_frames: got %0d want 4", frame_count); end
        n_checks++; if (busy !== 1'b1 || done !== 1'b0 || tlast_err !== 1'b0) begin n_fail++; $display("FAIL ul_status: got busy=%0b done=%0b err=%0b want 1/0/0", busy, done, tlast_err); end
        n_checks++; if (beat_count !== 16'd0 || s_tready !== 1'b1) begin n_fail++; $display("FAIL ul_idle_run: got beats=%0d rdy=%0b want 0/1", beat_count, s_tready); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        load_beats(64'h1000, 4, 0);
        do_start(12'd1);
        repeat (3) step();
        n_checks++; if (m_valid !== 1'b1 || beat_count !== 16'd3) begin n_fail++; $display("FAIL rm_pre: got mv=%0b beats=%0d want 1/3", m_valid, beat_count); end
        slave_rst = 1'b1;
        #1;
        n_checks++; if (m_valid !== 1'b0 || s_tready !== 1'b0 || m_tdata !== 64'h0 || m_tlast !== 1'b0) begin n_fail++; $display("FAIL rm_async_stream: got mv=%0b rdy=%0b data=%0h last=%0b want 0", m_valid, s_tready, m_tdata, m_tlast); end
        n_checks++; if (busy !== 1'b0 || beat_count !== 16'd0 || frame_count !== 12'd0) begin n_fail++; $display("FAIL rm_async_status: got busy=%0b beats=%0d frames=%0d want 0", busy, beat_count, frame_count); end
        @(posedge clk); #1;
        slave_rst = 1'b0;
        clear_bench();
        load_beats(64'h2000, 4, 0);
        do_start(12'd1);
        run_to_done(30, "rm");
        n_checks++; if (out_d.size() != 4) begin n_fail++; $display("FAIL rm_count: got %0d want 4", out_d.size()); end
        for (int i = 0; i < out_d.size(); i++) begin
            n_checks++;
            if (out_d[i] !== 64'h2000 + 64'(i) || out_l[i] !== (i == 3)) begin n_fail++; $display("FAIL rm_beat%0d: got %0h/%0b want %0h/%0b", i, out_d[i], out_l[i], 64'h2000 + 64'(i), i == 3); end
        end
        n_checks++; if (frame_count !== 12'd1 || tlast_err !== 1'b0) begin n_fail++; $display("FAIL rm_status: got frames=%0d err=%0b want 1/0", frame_count, tlast_err); end
    endtask

    initial begin
        test_reset();
        test_frame_tlast();
        test_tlast_err();
        test_backpressure();
        test_restart();
        test_unlimited();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
